// File: rtl/fp_unpack_pipe_pkg.sv
// Shared definitions for the FP operand unpacker: fclass bit positions and
// small elaboration-time helpers.
package fp_unpack_pipe_pkg;

  localparam int FCLASS_W    = 10;
  localparam int FCLASS_NINF = 0;
  localparam int FCLASS_NNORM = 1;
  localparam int FCLASS_NSUB = 2;
  localparam int FCLASS_NZERO = 3;
  localparam int FCLASS_PZERO = 4;
  localparam int FCLASS_PSUB = 5;
  localparam int FCLASS_PNORM = 6;
  localparam int FCLASS_PINF = 7;
  localparam int FCLASS_SNAN = 8;
  localparam int FCLASS_QNAN = 9;

  function automatic logic [FCLASS_W-1:0] fclass_bit(input int idx);
    return FCLASS_W'(1) << idx;
  endfunction

  // Smallest power of two that is >= n; sizes the leading-zero counter.
  function automatic int next_pow2(input int n);
    int p;
    p = 1;
    while (p < n) p = p * 2;
    return p;
  endfunction

endpackage

// File: rtl/fp_unpack_pipe_clz.sv
// Parametrised leading-zero counter; an all-zero input yields W_IN.
module fp_unpack_pipe_clz #(
  parameter int W_IN = 32
) (
  input  logic [W_IN-1:0]        data,
  output logic [$clog2(W_IN):0]  count
);

  localparam int CNT_W = $clog2(W_IN) + 1;

  // Ascending scan: the highest set bit is the last one to overwrite count.
  always_comb begin
    count = CNT_W'(W_IN);
    for (int i = 0; i < W_IN; i++) begin
      if (data[i]) count = CNT_W'(W_IN - 1 - i);
    end
  end

endmodule

// File: rtl/fp_unpack_pipe.sv
// Two-stage FP operand unpacker: NaN-box check, field split and CLZ in stage 1,
// fclass mask plus unbiased exponent / normalised significand in stage 2.
module fp_unpack_pipe
  import fp_unpack_pipe_pkg::*;
#(
  parameter int FLEN  = 32,
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [FLEN-1:0]    in_data_i,
  input  logic [TAG_W-1:0]   in_tag_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic               out_sign_o,
  output logic [EXP_W+1:0]   out_exp_o,
  output logic [MAN_W:0]     out_sig_o,
  output logic [FCLASS_W-1:0] out_class_o,
  output logic               out_unboxed_o,
  output logic [TAG_W-1:0]   out_tag_o
);

  localparam int FW    = EXP_W + MAN_W + 1;
  localparam int CLZ_W = next_pow2(MAN_W);
  localparam int CNT_W = $clog2(CLZ_W) + 1;
  localparam int LSH_W = $clog2(MAN_W + 2);
  localparam int XW    = EXP_W + 2;
  localparam logic [XW-1:0] BIAS = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic [FW-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // Handshake: a stage advances when it is empty or its successor advances;
  // a transfer happens on valid & ready at the clock edge, and a stalled
  // output holds its data. in_ready_o is combinational from out_ready_i.
  logic s1_valid, s2_valid;
  logic s1_adv, s2_adv;

  assign s2_adv      = !s2_valid || out_ready_i;
  assign s1_adv      = !s1_valid || s2_adv;
  assign in_ready_o  = s1_adv;
  assign out_valid_o = s2_valid;

  // ---------------- stage 1 combinational ----------------
  logic               unboxed;
  logic [FW-1:0]      operand;
  logic [EXP_W-1:0]   exp_field;
  logic [MAN_W-1:0]   man_field;
  logic [CLZ_W-1:0]   man_pad;
  logic [CNT_W-1:0]   lz;
  logic [LSH_W-1:0]   lshamt;

  generate
    if (FLEN > FW) begin : g_box
      assign unboxed = !(&in_data_i[FLEN-1:FW]);
    end else begin : g_nobox
      assign unboxed = 1'b0;
    end
  endgenerate

  assign operand   = unboxed ? QNAN : in_data_i[FW-1:0];
  assign exp_field = operand[FW-2:MAN_W];
  assign man_field = operand[MAN_W-1:0];
  assign man_pad   = CLZ_W'(man_field);

  fp_unpack_pipe_clz #(.W_IN(CLZ_W)) u_clz (
    .data  (man_pad),
    .count (lz)
  );

  // Distance to move the top set mantissa bit up to bit MAN_W.
  assign lshamt = LSH_W'(MAN_W + 1 - CLZ_W + int'(lz));

  // ---------------- stage 1 registers ----------------
  logic               s1_sign, s1_exp_zero, s1_exp_max, s1_man_zero, s1_unboxed;
  logic [EXP_W-1:0]   s1_exp;
  logic [MAN_W-1:0]   s1_man;
  logic [LSH_W-1:0]   s1_lshamt;
  logic [TAG_W-1:0]   s1_tag;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid    <= 1'b0;
      s1_sign     <= 1'b0;
      s1_exp      <= '0;
      s1_man      <= '0;
      s1_exp_zero <= 1'b0;
      s1_exp_max  <= 1'b0;
      s1_man_zero <= 1'b0;
      s1_lshamt   <= '0;
      s1_unboxed  <= 1'b0;
      s1_tag      <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid_i;
      if (in_valid_i) begin
        s1_sign     <= operand[FW-1];
        s1_exp      <= exp_field;
        s1_man      <= man_field;
        s1_exp_zero <= (exp_field == '0);
        s1_exp_max  <= &exp_field;
        s1_man_zero <= (man_field == '0);
        s1_lshamt   <= lshamt;
        s1_unboxed  <= unboxed;
        s1_tag      <= in_tag_i;
      end
    end
  end

  // ---------------- stage 2 decode ----------------
  // e - BIAS covers normal, zero (e = 0) and inf/NaN (e all ones) alike.
  logic [FCLASS_W-1:0] cls_d;
  logic [XW-1:0]       exp_d;
  logic [MAN_W:0]      sig_d;

  always_comb begin
    cls_d = '0;
    exp_d = {2'b00, s1_exp} - BIAS;
    sig_d = {1'b1, s1_man};
    if (s1_exp_max) begin
      if (s1_man_zero)
        cls_d = s1_sign ? fclass_bit(FCLASS_NINF) : fclass_bit(FCLASS_PINF);
      else if (s1_man[MAN_W-1])
        cls_d = fclass_bit(FCLASS_QNAN);
      else
        cls_d = fclass_bit(FCLASS_SNAN);
    end else if (s1_exp_zero) begin
      if (s1_man_zero) begin
        cls_d = s1_sign ? fclass_bit(FCLASS_NZERO) : fclass_bit(FCLASS_PZERO);
        sig_d = '0;
      end else begin
        cls_d = s1_sign ? fclass_bit(FCLASS_NSUB) : fclass_bit(FCLASS_PSUB);
        exp_d = XW'(1) - BIAS - XW'(s1_lshamt);
        sig_d = {1'b0, s1_man} << s1_lshamt;
      end
    end else begin
      cls_d = s1_sign ? fclass_bit(FCLASS_NNORM) : fclass_bit(FCLASS_PNORM);
    end
  end

  // ---------------- stage 2 registers ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s2_valid      <= 1'b0;
      out_sign_o    <= 1'b0;
      out_exp_o     <= '0;
      out_sig_o     <= '0;
      out_class_o   <= '0;
      out_unboxed_o <= 1'b0;
      out_tag_o     <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_sign_o    <= s1_sign;
        out_exp_o     <= exp_d;
        out_sig_o     <= sig_d;
        out_class_o   <= cls_d;
        out_unboxed_o <= s1_unboxed;
        out_tag_o     <= s1_tag;
      end
    end
  end

endmodule

// File: tb/tb_fp_unpack_pipe.sv
// Bench for fp_unpack_pipe: single, double and NaN-boxed single instances,
// directed vectors, backpressure, randomized traffic and mid-flight reset.
module tb_fp_unpack_pipe;

  localparam int NVEC = 10000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- single-precision instance ----------------
  logic        v32, r32, ordy32, ov32, o32_sign, o32_unb;
  logic [31:0] d32;
  logic [4:0]  t32, o32_tag;
  logic [9:0]  o32_exp, o32_cls;
  logic [23:0] o32_sig;

  fp_unpack_pipe #(.FLEN(32), .EXP_W(8), .MAN_W(23), .TAG_W(5)) u_s32 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(v32), .in_ready_o(r32), .in_data_i(d32),
    .in_tag_i(t32), .out_valid_o(ov32), .out_ready_i(ordy32), .out_sign_o(o32_sign),
    .out_exp_o(o32_exp), .out_sig_o(o32_sig), .out_class_o(o32_cls),
    .out_unboxed_o(o32_unb), .out_tag_o(o32_tag)
  );

  // ---------------- double-precision instance ----------------
  logic        vd, rd, ovd, od_sign, od_unb, ordy64;
  logic [63:0] dd;
  logic [4:0]  td, od_tag;
  logic [12:0] od_exp;
  logic [52:0] od_sig;
  logic [9:0]  od_cls;

  fp_unpack_pipe #(.FLEN(64), .EXP_W(11), .MAN_W(52), .TAG_W(5)) u_d64 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(vd), .in_ready_o(rd), .in_data_i(dd),
    .in_tag_i(td), .out_valid_o(ovd), .out_ready_i(ordy64), .out_sign_o(od_sign),
    .out_exp_o(od_exp), .out_sig_o(od_sig), .out_class_o(od_cls),
    .out_unboxed_o(od_unb), .out_tag_o(od_tag)
  );

  // ---------------- NaN-boxed single instance ----------------
  logic        vs, rs, ovs, os_sign, os_unb;
  logic [63:0] ds;
  logic [4:0]  ts, os_tag;
  logic [9:0]  os_exp, os_cls;
  logic [23:0] os_sig;

  fp_unpack_pipe #(.FLEN(64), .EXP_W(8), .MAN_W(23), .TAG_W(5)) u_b64 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(vs), .in_ready_o(rs), .in_data_i(ds),
    .in_tag_i(ts), .out_valid_o(ovs), .out_ready_i(ordy64), .out_sign_o(os_sign),
    .out_exp_o(os_exp), .out_sig_o(os_sig), .out_class_o(os_cls),
    .out_unboxed_o(os_unb), .out_tag_o(os_tag)
  );

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        sign;
    logic        unboxed;
    logic [9:0]  cls;
    logic [63:0] exp;
    logic [63:0] sig;
  } ref_t;

  // Works from the value's meaning: subnormals are normalised by doubling.
  function automatic ref_t ref_model(input int flen, input int ew, input int mw,
                                     input logic [63:0] raw);
    ref_t        r;
    int          fw, k;
    longint      bias, e, emax, x;
    logic [63:0] m, one_m, s;
    r     = '0;
    k     = 0;
    fw    = ew + mw + 1;
    bias  = (longint'(1) << (ew - 1)) - 1;
    emax  = (longint'(1) << ew) - 1;
    one_m = 64'd1 << mw;
    if (flen > fw && (raw >> fw) != ((64'd1 << (flen - fw)) - 1)) r.unboxed = 1'b1;
    if (r.unboxed) begin
      r.sign = 1'b0;
      e      = emax;
      m      = 64'd1 << (mw - 1);
    end else begin
      r.sign = raw[fw-1];
      e      = longint'((raw >> mw) & ((64'd1 << ew) - 1));
      m      = raw & (one_m - 1);
    end
    if (e == emax) begin
      r.exp = 64'(e - bias);
      r.sig = one_m + m;
      if (m == 0)                k = r.sign ? 0 : 7;
      else if (m >= (one_m >> 1)) k = 9;
      else                       k = 8;
    end else if (e == 0) begin
      if (m == 0) begin
        k     = r.sign ? 3 : 4;
        r.exp = 64'(-bias);
        r.sig = '0;
      end else begin
        k = r.sign ? 2 : 5;
        x = 1 - bias;
        s = m;
        while (s < one_m) begin
          s = s * 2;
          x = x - 1;
        end
        r.exp = 64'(x);
        r.sig = s;
      end
    end else begin
      k     = r.sign ? 1 : 6;
      r.exp = 64'(e - bias);
      r.sig = one_m + m;
    end
    r.cls = 10'd1 << k;
    return r;
  endfunction

  function automatic logic [50:0] pack_ref(input logic [4:0] tag, input ref_t r);
    return {tag, r.unboxed, r.sign, r.exp[9:0], r.sig[23:0], r.cls};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0]  e;
    logic [22:0] m;
    case ($urandom_range(0, 5))
      0:       e = 8'h00;
      1:       e = 8'hFF;
      default: e = 8'($urandom_range(1, 254));
    endcase
    case ($urandom_range(0, 3))
      0:       m = '0;
      1:       m = 23'd1 << $urandom_range(0, 22);
      default: m = 23'($urandom);
    endcase
    return {1'($urandom), e, m};
  endfunction

  // ---------------- scoreboard for the single instance ----------------
  logic [50:0] exp_q[$];
  logic        in_acc, out_acc;
  int          n_out = 0;

  // One clock of the single instance: sample at negedge, score after posedge.
  task automatic cycle32();
    logic [50:0] got;
    logic [31:0] data_s;
    logic [4:0]  tag_s;
    @(negedge clk);
    in_acc  = v32 && r32 && !rst;
    out_acc = ov32 && ordy32 && !rst;
    data_s  = d32;
    tag_s   = t32;
    got     = {o32_tag, o32_unb, o32_sign, o32_exp, o32_sig, o32_cls};
    @(posedge clk);
    #1;
    if (in_acc) exp_q.push_back(pack_ref(tag_s, ref_model(32, 8, 23, {32'd0, data_s})));
    if (out_acc) begin
      n_out++;
      check_val("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        check_val("sb_result", 64'(got), 64'(exp_q.pop_front()));
        check_val("onehot", 64'($countones(got[9:0])), 64'd1);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic directed32(input logic [31:0] data, input int cbit, input longint xexp,
                            input logic [23:0] xsig);
    longint le;
    v32 = 1'b1;
    d32 = data;
    t32 = 5'($urandom);
    cycle32();
    check_val("d32_accept", 64'(in_acc), 64'd1);
    v32 = 1'b0;
    check_val("d32_lat_edge_n", 64'(ov32), 64'd0);
    cycle32();
    check_val("d32_lat_edge_n1", 64'(ov32), 64'd1);
    le = $signed(o32_exp);
    check_val("d32_class", 64'(o32_cls), 64'(10'd1 << cbit));
    check_val("d32_exp", 64'(le), 64'(xexp));
    check_val("d32_sig", 64'(o32_sig), 64'(xsig));
    cycle32();
  endtask

  task automatic run64(input int which, input logic [63:0] data, input int cbit,
                       input longint xexp, input logic [63:0] xsig, input logic xunb);
    ref_t        r;
    longint      le;
    logic        val, sgn, unb;
    logic [9:0]  cls;
    logic [63:0] sig;
    r = ref_model(64, (which == 0) ? 11 : 8, (which == 0) ? 52 : 23, data);
    if (which == 0) begin vd = 1'b1; dd = data; end
    else            begin vs = 1'b1; ds = data; end
    @(posedge clk);
    #1;
    vd = 1'b0;
    vs = 1'b0;
    @(posedge clk);
    #1;
    if (which == 0) begin
      val = ovd; cls = od_cls; le = $signed(od_exp); sig = 64'(od_sig); sgn = od_sign; unb = od_unb;
    end else begin
      val = ovs; cls = os_cls; le = $signed(os_exp); sig = 64'(os_sig); sgn = os_sign; unb = os_unb;
    end
    check_val("d64_valid", 64'(val), 64'd1);
    check_val("d64_class", 64'(cls), 64'(10'd1 << cbit));
    check_val("d64_exp", 64'(le), 64'(xexp));
    check_val("d64_sig", sig, xsig);
    check_val("d64_unboxed", 64'(unb), 64'(xunb));
    check_val("d64_sign", 64'(sgn), 64'(r.sign));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int          n_sent, n_acc, n_off, n_out0, cyc;
    logic [50:0] snap;
    rst = 1'b1;
    v32 = 1'b0; d32 = '0; t32 = '0; ordy32 = 1'b1;
    vd = 1'b0; dd = '0; td = '0; vs = 1'b0; ds = '0; ts = '0; ordy64 = 1'b1;
    in_acc = 1'b0; out_acc = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_val("rst_out_valid", 64'(ov32), 64'd0);
    check_val("rst_in_ready", 64'(r32), 64'd1);
    check_val("rst_outputs", 64'({o32_tag, o32_unb, o32_sign, o32_exp, o32_sig, o32_cls}), 64'd0);

    // single precision, ready held high
    directed32(32'h3F800000, 6, 0,    24'h800000);
    directed32(32'h00000001, 5, -149, 24'h800000);
    directed32(32'h80000000, 3, -127, 24'h000000);
    directed32(32'hFF800000, 0, 128,  24'h800000);
    directed32(32'h7FC00000, 9, 128,  24'hC00000);
    directed32(32'h7F800001, 8, 128,  24'h800001);

    // double precision and NaN-boxed single
    run64(0, 64'h000FFFFFFFFFFFFF, 5, -1023, 64'h1FFFFFFFFFFFFE, 1'b0);
    run64(0, 64'h4000000000000000, 6, 1,     64'h10000000000000, 1'b0);
    run64(1, 64'hFFFFFFFF3F800000, 6, 0,     64'h800000,         1'b0);
    run64(1, 64'h000000003F800000, 9, 128,   64'hC00000,         1'b1);

    // backpressure: four inputs, consumer stalled for three cycles
    ordy32 = 1'b0;
    n_sent = 0;
    v32 = 1'b1; d32 = rand_fp(); t32 = 5'(n_sent);
    snap = '0;
    for (int c = 0; c < 3; c++) begin
      cycle32();
      if (in_acc) begin
        n_sent++;
        d32 = rand_fp();
        t32 = 5'(n_sent);
      end
      if (c == 1) snap = {o32_tag, o32_unb, o32_sign, o32_exp, o32_sig, o32_cls};
      if (c == 2) check_val("bp_stable", 64'({o32_tag, o32_unb, o32_sign, o32_exp, o32_sig, o32_cls}), 64'(snap));
    end
    check_val("bp_accepts", 64'(n_sent), 64'd2);
    check_val("bp_ready_low", 64'(r32), 64'd0);
    check_val("bp_valid_held", 64'(ov32), 64'd1);
    ordy32 = 1'b1;
    cyc = 0;
    while ((n_sent < 4 || exp_q.size() != 0) && cyc < 40) begin
      cycle32();
      cyc++;
      if (in_acc) begin
        n_sent++;
        if (n_sent == 4) v32 = 1'b0;
        else begin d32 = rand_fp(); t32 = 5'(n_sent); end
      end
    end
    check_val("bp_all_sent", 64'(n_sent), 64'd4);
    check_val("bp_drained", 64'(exp_q.size()), 64'd0);

    // randomized valid/ready traffic
    n_acc = 0; n_off = 0; n_out0 = n_out; cyc = 0;
    v32 = 1'b0;
    while ((n_acc < NVEC || exp_q.size() != 0) && cyc < 60000) begin
      if (!v32 && n_off < NVEC && $urandom_range(0, 3) != 0) begin
        v32 = 1'b1;
        d32 = rand_fp();
        t32 = 5'($urandom);
        n_off++;
      end
      ordy32 = ($urandom_range(0, 3) != 0);
      cycle32();
      cyc++;
      if (in_acc) begin
        n_acc++;
        v32 = 1'b0;
      end
    end
    check_val("rand_no_timeout", 64'(cyc < 60000), 64'd1);
    check_val("rand_accepted", 64'(n_acc), 64'(NVEC));
    check_val("rand_outputs", 64'(n_out - n_out0), 64'(NVEC));
    check_val("rand_queue_empty", 64'(exp_q.size()), 64'd0);

    // reset with both stages full
    ordy32 = 1'b0;
    v32 = 1'b1; d32 = rand_fp(); t32 = 5'($urandom);
    cycle32();
    d32 = rand_fp();
    cycle32();
    check_val("pre_rst_out_valid", 64'(ov32), 64'd1);
    check_val("pre_rst_in_ready", 64'(r32), 64'd0);
    rst = 1'b1;
    d32 = rand_fp();
    cycle32();
    check_val("rst_cycle_no_accept", 64'(in_acc), 64'd0);
    rst = 1'b0;
    v32 = 1'b0;
    exp_q.delete();
    check_val("mid_rst_out_valid", 64'(ov32), 64'd0);
    check_val("mid_rst_in_ready", 64'(r32), 64'd1);
    check_val("mid_rst_outputs", 64'({o32_tag, o32_unb, o32_sign, o32_exp, o32_sig, o32_cls}), 64'd0);
    ordy32 = 1'b1;
    n_out0 = n_out;
    repeat (6) cycle32();
    check_val("no_stale_after_rst", 64'(n_out - n_out0), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
